// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divide-by-2 pixel enable, h/v counters, sync decode
// and a one-pixel output register stage that drives the DAC pins.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic       VGA_Clk,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       frame_clk,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pe;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_last;
  logic       v_last;
  logic       hs_raw;
  logic       vs_raw;

  // pixel enable: high on every other Clk, doubles as the pixel clock output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pe <= 1'b0;
    end else begin
      pe <= ~pe;
    end
  end

  assign VGA_Clk = pe;

  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (pe) begin
      if (h_last) begin
        hc <= '0;
        if (v_last) begin
          vc <= '0;
        end else begin
          vc <= vc + 10'd1;
        end
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // cleared on the following (non-pe) edge, so it lasts exactly one Clk
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pe & h_last & v_last;
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = (hc < H_VIS) && (vc < V_VIS);
  assign hs_raw = !((hc >= HS_BEG) && (hc < HS_END));
  assign vs_raw = !((vc >= VS_BEG) && (vc < VS_END));

  // output stage: sync, enable and colour stay mutually aligned, one pixel late
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (pe) begin
      VGA_HS      <= hs_raw;
      VGA_VS      <= vs_raw;
      VGA_BLANK_N <= blank;
      VGA_R       <= blank ? Red   : 8'h00;
      VGA_G       <= blank ? Green : 8'h00;
      VGA_B       <= blank ? Blue  : 8'h00;
    end
  end

  assign frame_clk = VGA_VS;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; full horizontal timing, shortened vertical
// timing (12 lines: 6 visible, front 2, sync 2, back 2) to keep frames short.
module tb_vga_timing_gen;

  logic       Clk;
  logic       Reset_n;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic       VGA_Clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       frame_clk;
  logic       frame_start;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  int tests;
  int fails;

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(6),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red(Red), .Green(Green), .Blue(Blue),
    .VGA_Clk(VGA_Clk), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_clk(frame_clk), .frame_start(frame_start),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one Clk; sample #1 after the edge, then present the mapper's colour
  task automatic step();
    @(posedge Clk);
    #1;
    Red   = DrawX[7:0];
    Green = 8'h5A;
    Blue  = 8'hC3;
  endtask

  task automatic run_until_xy(input int x, input int y, input int limit, output int n);
    n = 0;
    while (!(int'(DrawX) == x && int'(DrawY) == y) && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_drawx"},   32'(DrawX), 0);
    chk({pfx, "_drawy"},   32'(DrawY), 0);
    chk({pfx, "_vgaclk"},  32'(VGA_Clk), 0);
    chk({pfx, "_hs"},      32'(VGA_HS), 1);
    chk({pfx, "_vs"},      32'(VGA_VS), 1);
    chk({pfx, "_frclk"},   32'(frame_clk), 1);
    chk({pfx, "_blank_n"}, 32'(VGA_BLANK_N), 0);
    chk({pfx, "_rgb"},     {8'h00, VGA_R, VGA_G, VGA_B}, 0);
    chk({pfx, "_blank"},   32'(blank), 1);
    chk({pfx, "_fstart"},  32'(frame_start), 0);
  endtask

  initial begin
    int n;
    int blank_lo, hs_lo, hs_first_x, max_x, col_err;
    int vs_lo, fs_cnt, fs_at, max_y, frclk_err;
    tests = 0;
    fails = 0;
    Red = 8'h00; Green = 8'h00; Blue = 8'h00;
    Reset_n = 1'b0;

    // reset held for 5 Clk
    repeat (5) step();
    check_reset_values("rst");

    // cold start: first pe edge on the 2nd Clk, next line at 800 pixels
    Reset_n = 1'b1;
    step();
    chk("cold_x_clk1", 32'(DrawX), 0);
    chk("cold_vgaclk_clk1", 32'(VGA_Clk), 1);
    step();
    chk("cold_x_clk2", 32'(DrawX), 1);
    run_until_xy(0, 1, 4000, n);
    chk("cold_line_clks", n + 2, 1600);

    // one full line (row 1) starting at pixel 0
    blank_lo = 0; hs_lo = 0; hs_first_x = -1; max_x = 0; col_err = 0;
    for (int i = 0; i < 1600; i++) begin
      if (!blank) blank_lo++;
      if (!VGA_HS) begin
        hs_lo++;
        if (hs_first_x < 0) hs_first_x = int'(DrawX);
      end
      if (int'(DrawX) > max_x) max_x = int'(DrawX);
      if (VGA_BLANK_N) begin
        if (VGA_R !== 8'(DrawX - 10'd1) || VGA_G !== 8'h5A || VGA_B !== 8'hC3) col_err++;
      end else begin
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) col_err++;
      end
      step();
    end
    chk("line_blank_low_clks", blank_lo, 320);
    chk("line_hs_low_clks", hs_lo, 192);
    chk("line_hs_fall_x", hs_first_x, 657);
    chk("line_max_x", max_x, 799);
    chk("line_colour_errs", col_err, 0);
    chk("line_end_xy", {6'd0, DrawY, 6'd0, DrawX}, {6'd0, 10'd2, 6'd0, 10'd0});

    // frame wrap at (799, 11)
    run_until_xy(799, 11, 40000, n);
    chk("wrap_reached", 32'(n < 40000), 1);
    chk("wrap_pre_blank", 32'(blank), 0);
    chk("wrap_pre_fstart", 32'(frame_start), 0);
    step();
    chk("wrap_mid_fstart", 32'(frame_start), 0);
    step();
    chk("wrap_xy", {6'd0, DrawY, 6'd0, DrawX}, 0);
    chk("wrap_blank", 32'(blank), 1);
    chk("wrap_fstart", 32'(frame_start), 1);

    // one full frame from the frame_start Clk
    vs_lo = 0; fs_cnt = 0; fs_at = -1; max_y = 0; frclk_err = 0;
    for (int i = 1; i <= 19200; i++) begin
      step();
      if (frame_start) begin
        fs_cnt++;
        fs_at = i;
      end
      if (!VGA_VS) vs_lo++;
      if (int'(DrawY) > max_y) max_y = int'(DrawY);
      if (frame_clk !== VGA_VS) frclk_err++;
    end
    chk("frame_fstart_count", fs_cnt, 1);
    chk("frame_fstart_period", fs_at, 19200);
    chk("frame_vs_low_clks", vs_lo, 3200);
    chk("frame_max_y", max_y, 11);
    chk("frame_frclk_errs", frclk_err, 0);

    // asynchronous reset mid-frame at (300, 3)
    run_until_xy(300, 3, 20000, n);
    chk("midrst_reached", 32'(n < 20000), 1);
    chk("midrst_pre_blank_n", 32'(VGA_BLANK_N), 1);
    #4;
    Reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (3) step();
    Reset_n = 1'b1;
    step();
    chk("warm_x_clk1", 32'(DrawX), 0);
    chk("warm_vgaclk_clk1", 32'(VGA_Clk), 1);
    step();
    chk("warm_x_clk2", 32'(DrawX), 1);
    run_until_xy(0, 1, 4000, n);
    chk("warm_line_clks", n + 2, 1600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
